// File: rtl/alu_sched_pkg.sv
// Shared state encoding and constants for the vector ALU sequencer.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_AND    = 3'd2;
  localparam logic [2:0] OP_OR     = 3'd3;
  localparam logic [2:0] OP_XOR    = 3'd4;
  localparam logic [2:0] OP_MUL    = 3'd5;
  localparam logic [2:0] OP_PASS_A = 3'd6;
  localparam logic [2:0] OP_PASS_B = 3'd7;

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_GT    = 2;
  localparam int FLAG_EQ    = 1;
  localparam int FLAG_LT    = 0;

endpackage

// File: rtl/alu_sched_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module alu_sched_rr_arb (
  input  logic       clk,
  input  logic       arst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
  end

  // After a grant the pointer favours whoever lost: r0 granted -> 1, r1 granted -> 0.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = grant[0];
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/alu_vec_sched.sv
// Sequencer/arbiter driving the shared vector ALU for two requesters.
// Optional performance counters are built when ALU_SCHED_PERF_EN is defined.
module alu_vec_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int N_ALU   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [5:0]                 req_op,
  input  logic [2*WIDTH*N_ALU-1:0]   req_a,
  input  logic [2*WIDTH*N_ALU-1:0]   req_b,
  input  logic [2*N_ALU-1:0]         req_mask,
  output logic [2:0]                 alu_select,
  output logic [WIDTH*N_ALU-1:0]     alu_a,
  output logic [WIDTH*N_ALU-1:0]     alu_b,
  output logic [N_ALU-1:0]           alu_enable,
  input  logic [2*WIDTH*N_ALU-1:0]   alu_data_out,
  input  logic [3:0]                 alu_flags,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [2*WIDTH*N_ALU-1:0]   rsp_data,
  output logic [3:0]                 rsp_flags,
  output logic                       busy
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_ops,
  output logic [31:0]                perf_stall
`endif
);

  // state    | meaning
  // ST_IDLE  | no op in flight, arbitration live, req_ready may assert
  // ST_ISSUE | single cycle with alu_enable = registered mask
  // ST_WAIT  | counting out the ALU latency, capture on the last cycle
  // ST_DONE  | response presented until rsp_ready

  localparam int LW = WIDTH * N_ALU;
  localparam int RW = 2 * LW;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [LW-1:0]    a_q, a_d, b_q, b_d;
  logic [N_ALU-1:0] mask_q, mask_d;
  logic             id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    data_q, data_d;
  logic [3:0]       flags_q, flags_d;
  logic [1:0]       grant;
  logic             arb_ptr;
  logic             accept;
  logic [RW-1:0]    data_masked;

  assign accept = (state_q == ST_IDLE) && (|req_valid);

  alu_sched_rr_arb u_arb (
    .clk     (clk),
    .arst    (arst),
    .valid   (req_valid),
    .advance (accept),
    .grant   (grant),
    .ptr     (arb_ptr)
  );

  for (genvar i = 0; i < N_ALU; i++) begin : g_lane
    assign data_masked[2*WIDTH*i +: 2*WIDTH] =
      mask_q[i] ? alu_data_out[2*WIDTH*i +: 2*WIDTH] : '0;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    mask_d    = mask_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    flags_d   = flags_q;
    req_ready = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_ready = grant;
          id_d      = (req_valid == 2'b11) ? arb_ptr : req_valid[1];
          op_d      = id_d ? req_op[5:3] : req_op[2:0];
          a_d       = id_d ? req_a[RW-1:LW] : req_a[LW-1:0];
          b_d       = id_d ? req_b[RW-1:LW] : req_b[LW-1:0];
          mask_d    = id_d ? req_mask[2*N_ALU-1:N_ALU] : req_mask[N_ALU-1:0];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CW'(ALU_LAT - 1)) begin
          data_d  = data_masked;
          flags_d = alu_flags;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign alu_select = busy ? op_q : '0;
  assign alu_a      = busy ? a_q : '0;
  assign alu_b      = busy ? b_q : '0;
  assign alu_enable = (state_q == ST_ISSUE) ? mask_q : '0;
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_flags  = flags_q;

`ifdef ALU_SCHED_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (state_q == ST_DONE) begin
      if (rsp_ready) perf_ops_d   = perf_ops_q + 32'd1;
      else           perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_vec_sched.sv
// Bench for alu_vec_sched: emulated ALU, cycle-level response model, directed vectors.
module tb_alu_vec_sched;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int LW = W * N;
  localparam int RW = 2 * LW;
  localparam logic [RW-1:0] JUNK_D = 32'hA5A5A5A5;
  localparam logic [3:0]    JUNK_F = 4'b0110;

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req_valid, req_ready;
  logic [5:0]    req_op;
  logic [RW-1:0] req_a, req_b;
  logic [2*N-1:0] req_mask;
  logic [2:0]    alu_select;
  logic [LW-1:0] alu_a, alu_b;
  logic [N-1:0]  alu_enable;
  logic [RW-1:0] alu_data_out;
  logic [3:0]    alu_flags;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [RW-1:0] rsp_data;
  logic [3:0]    rsp_flags;

  logic [1:0]    s3_req_valid, s3_req_ready;
  logic [5:0]    s3_req_op;
  logic [RW-1:0] s3_req_a, s3_req_b;
  logic [2*N-1:0] s3_req_mask;
  logic [2:0]    s3_alu_select;
  logic [LW-1:0] s3_alu_a, s3_alu_b;
  logic [N-1:0]  s3_alu_enable;
  logic [RW-1:0] s3_alu_data_out;
  logic [3:0]    s3_alu_flags;
  logic          s3_rsp_valid, s3_rsp_ready, s3_rsp_id, s3_busy;
  logic [RW-1:0] s3_rsp_data;
  logic [3:0]    s3_rsp_flags;
`ifdef ALU_SCHED_PERF_EN
  logic [31:0] perf_ops, perf_stall, s3_perf_ops, s3_perf_stall;
`endif

  alu_vec_sched #(.WIDTH(W), .N_ALU(N), .ALU_LAT(1)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_mask(req_mask),
    .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_enable(alu_enable),
    .alu_data_out(alu_data_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
`ifdef ALU_SCHED_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  alu_vec_sched #(.WIDTH(W), .N_ALU(N), .ALU_LAT(3)) dut3 (
    .clk(clk), .arst(arst), .req_valid(s3_req_valid), .req_ready(s3_req_ready),
    .req_op(s3_req_op), .req_a(s3_req_a), .req_b(s3_req_b), .req_mask(s3_req_mask),
    .alu_select(s3_alu_select), .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_enable(s3_alu_enable),
    .alu_data_out(s3_alu_data_out), .alu_flags(s3_alu_flags),
    .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_id(s3_rsp_id),
    .rsp_data(s3_rsp_data), .rsp_flags(s3_rsp_flags), .busy(s3_busy)
`ifdef ALU_SCHED_PERF_EN
    , .perf_ops(s3_perf_ops), .perf_stall(s3_perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: per-lane 8-bit results, flags taken from lane 0.
  function automatic logic [35:0] alu_f(input logic [2:0] op, input logic [LW-1:0] a,
                                        input logic [LW-1:0] b);
    logic [RW-1:0] d;
    logic [3:0] fl, ai, bi;
    logic [7:0] r;
    d = '0;
    for (int i = 0; i < N; i++) begin
      ai = a[4*i +: 4];
      bi = b[4*i +: 4];
      case (op)
        3'd0:    r = {4'b0, ai} + {4'b0, bi};
        3'd1:    r = {4'b0, ai} - {4'b0, bi};
        3'd2:    r = {4'b0, ai & bi};
        3'd3:    r = {4'b0, ai | bi};
        3'd4:    r = {4'b0, ai ^ bi};
        3'd5:    r = {4'b0, ai} * {4'b0, bi};
        default: r = {4'b0, ai};
      endcase
      d[8*i +: 8] = r;
    end
    fl[3] = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
    fl[2] = a[3:0] > b[3:0];
    fl[1] = a[3:0] == b[3:0];
    fl[0] = a[3:0] < b[3:0];
    return {fl, d};
  endfunction

  // Emulated ALUs: result appears ALU_LAT cycles after an enable edge, junk otherwise.
  logic [35:0] p1 = '0;
  logic [35:0] p3 [3] = '{default: '0};
  always @(posedge clk) begin
    p1    <= (|alu_enable) ? alu_f(alu_select, alu_a, alu_b) : {JUNK_F, JUNK_D};
    p3[0] <= (|s3_alu_enable) ? alu_f(s3_alu_select, s3_alu_a, s3_alu_b) : {JUNK_F, JUNK_D};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign alu_data_out    = p1[RW-1:0];
  assign alu_flags       = p1[35:32];
  assign s3_alu_data_out = p3[2][RW-1:0];
  assign s3_alu_flags    = p3[2][35:32];

  // Cycle-level model of the LAT=1 instance: m_t counts cycles since the accept edge.
  bit             m_busy, m_ptr, m_id;
  int             m_t, m_ops, m_stall;
  logic [2:0]     m_op;
  logic [LW-1:0]  m_a, m_b;
  logic [N-1:0]   m_mask;
  logic [RW-1:0]  m_data;
  logic [3:0]     m_flags;

  always @(negedge clk) begin
    logic [1:0]  g;
    logic [35:0] r;
    if (!arst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_alu_enable", alu_enable, 0);
      chk("rst_alu_select", alu_select, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_flags", rsp_flags, 0);
      chk("rst_busy", busy, 0);
      m_busy = 0; m_ptr = 0; m_t = 0; m_ops = 0; m_stall = 0;
    end else begin
      g = 2'b00;
      if (!m_busy) g = (req_valid == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : req_valid;
      chk("req_ready", req_ready, g);
      chk("busy", busy, m_busy);
      chk("alu_enable", alu_enable, (m_busy && m_t == 1) ? m_mask : 4'h0);
      if (m_busy) begin
        chk("alu_select", alu_select, m_op);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
      end
      chk("rsp_valid", rsp_valid, m_busy && m_t >= 3);
      if (m_busy && m_t >= 3) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_flags", rsp_flags, m_flags);
      end
`ifdef ALU_SCHED_PERF_EN
      chk("perf_ops", perf_ops, 32'(m_ops));
      chk("perf_stall", perf_stall, 32'(m_stall));
`endif
      if (!m_busy) begin
        if (g != 2'b00) begin
          m_busy = 1; m_t = 1;
          m_id   = g[1];
          m_ptr  = g[0];
          m_op   = m_id ? req_op[5:3] : req_op[2:0];
          m_a    = m_id ? req_a[RW-1:LW] : req_a[LW-1:0];
          m_b    = m_id ? req_b[RW-1:LW] : req_b[LW-1:0];
          m_mask = m_id ? req_mask[2*N-1:N] : req_mask[N-1:0];
          r      = alu_f(m_op, m_a, m_b);
          for (int i = 0; i < N; i++)
            m_data[8*i +: 8] = m_mask[i] ? r[8*i +: 8] : 8'h00;
          m_flags = (m_mask == 0) ? JUNK_F : r[35:32];
        end
      end else if (m_t >= 3) begin
        if (rsp_ready) begin m_busy = 0; m_ops++; end
        else m_stall++;
      end else begin
        m_t++;
      end
    end
  end

  task automatic send(input int r, input logic [2:0] op, input logic [LW-1:0] a,
                      input logic [LW-1:0] b, input logic [N-1:0] m);
    int k;
    @(posedge clk); #1;
    if (r == 0) begin
      req_op[2:0] = op; req_a[LW-1:0] = a; req_b[LW-1:0] = b; req_mask[N-1:0] = m;
    end else begin
      req_op[5:3] = op; req_a[RW-1:LW] = a; req_b[RW-1:LW] = b; req_mask[2*N-1:N] = m;
    end
    req_valid[r] = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready[r]) break;
    end
    chk("send_grant", req_ready[r], 1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  // Called one cycle after the accept edge; returns the cycle index of first rsp_valid.
  task automatic wait_rsp(output int n);
    for (n = 1; n < 60; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain", busy, 0);
  endtask

  initial begin
    int n, k;
    int gq[$];
    logic [RW-1:0] d0;
    logic [3:0] f0;
    logic [31:0] base;
    req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_mask = 0; rsp_ready = 1;
    s3_req_valid = 0; s3_req_op = 0; s3_req_a = 0; s3_req_b = 0; s3_req_mask = 0;
    s3_rsp_ready = 1;
    base = 0;
    repeat (3) @(posedge clk);
    #1 arst = 1'b1;

    chk("model_add", alu_f(3'd0, 16'h3333, 16'h1111), {4'b0100, 32'h04040404});
    chk("model_mul", alu_f(3'd5, 16'h4321, 16'h5555), {4'b0001, 32'h140F0A05});
    chk("model_xor", alu_f(3'd4, 16'hFFFF, 16'h0F0F), {4'b1010, 32'h0F000F00});

    // ALU_LAT = 3 instance: rsp_valid first high five cycles after accept
    @(posedge clk); #1;
    s3_req_op = 6'b100_000; s3_req_a = {16'hFFFF, 16'h0}; s3_req_b = {16'h0F0F, 16'h0};
    s3_req_mask = 8'hF0; s3_req_valid = 2'b10;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s3_req_ready[1]) break;
    end
    chk("lat3_grant", s3_req_ready, 2'b10);
    @(posedge clk); #1;
    s3_req_valid = 2'b00;
    for (n = 1; n < 60; n++) begin
      @(negedge clk);
      if (s3_rsp_valid) break;
      @(posedge clk);
    end
    chk("lat3_cycle", n, 5);
    chk("lat3_data", s3_rsp_data, 32'h0F000F00);
    chk("lat3_flags", s3_rsp_flags, 4'b1010);
    chk("lat3_id", s3_rsp_id, 1);

    // single request r0, ALU_LAT = 1
    send(0, 3'd0, 16'h3333, 16'h1111, 4'hF);
    wait_rsp(n);
    chk("t1_cycle", n, 3);
    chk("t1_data", rsp_data, 32'h04040404);
    chk("t1_flags", rsp_flags, 4'b0100);
    chk("t1_id", rsp_id, 0);
    drain();

    // partial mask
    send(1, 3'd5, 16'h4321, 16'h5555, 4'h5);
    wait_rsp(n);
    chk("mask5_cycle", n, 3);
    chk("mask5_data", rsp_data, 32'h000F0005);
    chk("mask5_flags", rsp_flags, 4'b0001);
    chk("mask5_id", rsp_id, 1);
    drain();

    // mask 0: sequence still runs, data zero, flags as the idle ALU shows them
    send(0, 3'd2, 16'hABCD, 16'h1234, 4'h0);
    wait_rsp(n);
    chk("mask0_data", rsp_data, 32'h0);
    chk("mask0_flags", rsp_flags, JUNK_F);
    drain();

    // both requesters always valid: grants alternate
    @(posedge clk); #1;
    req_op = {3'd1, 3'd0}; req_a = {16'h9876, 16'h1234}; req_b = {16'h1111, 16'h4321};
    req_mask = {4'hA, 4'hF}; req_valid = 2'b11;
    repeat (30) begin
      @(negedge clk);
      if (req_ready != 2'b00) gq.push_back(int'(req_ready[1]));
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("rr_count", gq.size() >= 6, 1);
    for (int i = 1; i < gq.size(); i++) chk("rr_alternate", gq[i], 1 - gq[i-1]);
    drain();

    // DONE stall: rsp_ready low for 10 DONE cycles
    @(posedge clk); #1;
    rsp_ready = 1'b0;
`ifdef ALU_SCHED_PERF_EN
    base = perf_stall;
`endif
    send(0, 3'd3, 16'h0F0F, 16'h3030, 4'hF);
    req_op[5:3] = 3'd4; req_a[RW-1:LW] = 16'h5555; req_b[RW-1:LW] = 16'h0101;
    req_mask[2*N-1:N] = 4'hF; req_valid[1] = 1'b1;
    wait_rsp(n);
    chk("stall_cycle", n, 3);
    d0 = rsp_data;
    f0 = rsp_flags;
    chk("stall_data", d0, 32'h030F030F);
    chk("stall_flags", f0, 4'b0100);
    for (int c = 1; c <= 10; c++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_hold_data", rsp_data, d0);
      chk("stall_hold_flags", rsp_flags, f0);
      chk("stall_req_ready", req_ready, 0);
      if (c < 10) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
`ifdef ALU_SCHED_PERF_EN
    chk("perf_stall_10", perf_stall - base, 10);
`endif
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[1]) break;
    end
    chk("after_stall_r1", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // async reset during WAIT; r0 granted leaves the pointer at 1 before reset
    send(0, 3'd0, 16'h1111, 16'h2222, 4'hF);
    @(posedge clk); #2;
    chk("pre_rst_busy", busy, 1);
    arst = 1'b0;
    #1;
    chk("arst_enable", alu_enable, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_alu_a", alu_a, 0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("post_rst_ptr0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[1]) break;
    end
    chk("post_rst_r1", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
